// File: rtl/packet_filter_pkg.sv
// Shared types and constants for the frame checker: FSM states, header layout,
// status bit positions and the register map.
`ifndef STUBBING_PASSTHROUGH
`define STUBBING_PASSTHROUGH 0
`endif

package packet_filter_pkg;

  typedef enum logic [1:0] {
    ST_HDR     = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_e;

  localparam logic [15:0] DST_OFF   = 16'd0;
  localparam logic [15:0] SRC_OFF   = 16'd6;
  localparam logic [15:0] LEN_OFF   = 16'd12;
  localparam logic [15:0] TYPE_OFF  = 16'd14;
  localparam logic [15:0] HDR_BYTES = 16'd16;

  localparam int STAT_LEN_ERR  = 0;
  localparam int STAT_DST_MIS  = 1;
  localparam int STAT_RUNT     = 2;
  localparam int STAT_OVERSIZE = 3;
  localparam int STAT_VALID    = 7;

  localparam logic [7:0] ADDR_MAC5     = 8'd5;
  localparam logic [7:0] ADDR_CTRL     = 8'd6;
  localparam logic [7:0] ADDR_THROTTLE = 8'd7;
  localparam logic [7:0] ADDR_OK0      = 8'd8;
  localparam logic [7:0] ADDR_BAD0     = 8'd12;
  localparam logic [7:0] ADDR_CSUM0    = 8'd14;
  localparam logic [7:0] ADDR_LEN0     = 8'd18;
  localparam logic [7:0] ADDR_STATUS   = 8'd20;
  localparam logic [7:0] ADDR_SRC5     = 8'd26;

  function automatic logic [7:0] byte_of(input logic [47:0] v, input logic [2:0] idx);
    logic [47:0] s;
    s = v >> {idx, 3'b000};
    return s[7:0];
  endfunction

endpackage

// File: rtl/stream_throttle.sv
// Back-pressure mask: with n > 0, drops ready for one cycle in every n+1.
module stream_throttle (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] n,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       mask
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    if (load)              cnt_d = load_val;
    else if (cnt_q == 8'd0) cnt_d = n;
    else                   cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= 8'd0;
    else          cnt_q <= cnt_d;
  end

  assign mask = (n == 8'd0) || (cnt_q != 8'd0);

endmodule

// File: rtl/frame_checker.sv
// Stream sink that parses frame headers, sums payload bytes, flags errors and
// exposes per-frame results and counters on an 8-bit Avalon-MM slave.
`ifndef STUBBING_PASSTHROUGH
`define STUBBING_PASSTHROUGH 0
`endif

// state   | meaning
// HDR     | collecting the 16 header bytes
// PAYLOAD | summing payload bytes
// DROP    | frame exceeded max length, discarding until tlast
module frame_checker
  import packet_filter_pkg::*;
#(
  parameter int STUBBING        = `STUBBING_PASSTHROUGH,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  writedata,
  input  logic        write,
  input  logic        chipselect,
  input  logic [7:0]  address,
  input  logic        read,
  output logic [7:0]  readdata,
  input  logic [15:0] ingress_port_tdata,
  input  logic        ingress_port_tlast,
  input  logic        ingress_port_tvalid,
  output logic        ingress_port_tready
);

  localparam bit          FUNCTIONAL = (STUBBING != `STUBBING_PASSTHROUGH);
  localparam logic [16:0] MAX_B      = 17'(MAX_FRAME_BYTES);

  state_e      state_q, state_d;
  logic [15:0] byte_cnt_q, byte_cnt_d, len_q, len_d;
  logic [47:0] dst_q, dst_d, src_q, src_d, mac_q, mac_d;
  logic [31:0] csum_q, csum_d, ok_q, ok_d, last_csum_q, last_csum_d;
  logic [15:0] bad_q, bad_d, last_len_q, last_len_d;
  logic [7:0]  ctrl_q, ctrl_d, thr_q, thr_d, last_status_q, last_status_d;
  logic [47:0] last_src_q, last_src_d;
  logic [7:0]  readdata_q, readdata_d, rd;

  logic        mask, xfer, commit, wr, clr, thr_load;
  logic        runt, len_err, dst_mis, oversize;
  logic [16:0] nb;
  logic [17:0] exp_total;
  logic [7:0]  status;
  logic [5:0]  wsh;
  logic [47:0] wmask;

  assign wr       = chipselect && write;
  assign clr      = wr && (address == ADDR_CTRL) && writedata[1];
  assign thr_load = wr && (address == ADDR_THROTTLE);
  assign xfer     = ingress_port_tvalid && ingress_port_tready;
  assign commit   = xfer && ingress_port_tlast;

  stream_throttle u_throttle (
    .clk      (clk),
    .reset_n  (reset_n),
    .n        (thr_q),
    .load     (thr_load),
    .load_val (writedata),
    .mask     (mask)
  );

  assign ingress_port_tready = reset_n && (!FUNCTIONAL || mask);
  assign readdata            = (reset_n && FUNCTIONAL) ? readdata_q : 8'd0;

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    dst_d         = dst_q;
    src_d         = src_q;
    len_d         = len_q;
    csum_d        = csum_q;
    last_csum_d   = last_csum_q;
    last_len_d    = last_len_q;
    last_status_d = last_status_q;
    last_src_d    = last_src_q;
    nb            = {1'b0, byte_cnt_q} + 17'd2;
    if (xfer) begin
      byte_cnt_d = nb[15:0];
      case (state_q)
        ST_HDR: begin
          if (byte_cnt_q < SRC_OFF)       dst_d = {dst_q[31:0], ingress_port_tdata};
          else if (byte_cnt_q < LEN_OFF)  src_d = {src_q[31:0], ingress_port_tdata};
          else if (byte_cnt_q == LEN_OFF) len_d = {ingress_port_tdata[7:0], ingress_port_tdata[15:8]};
          if (nb == {1'b0, HDR_BYTES}) state_d = ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          // The beat that crosses the limit is already outside the summed range.
          if (nb > MAX_B) state_d = ST_DROP;
          else csum_d = csum_q + 32'(ingress_port_tdata[15:8]) + 32'(ingress_port_tdata[7:0]);
        end
        default: ;
      endcase
    end
    exp_total = 18'd16 + {2'b00, len_d} + {17'd0, len_d[0]};
    runt      = nb < {1'b0, HDR_BYTES};
    len_err   = !runt && ({1'b0, nb} != exp_total);
    dst_mis   = ctrl_q[0] && (dst_d != mac_q);
    oversize  = (state_q == ST_DROP) || (nb > MAX_B);
    status                = 8'd0;
    status[STAT_LEN_ERR]  = len_err;
    status[STAT_DST_MIS]  = dst_mis;
    status[STAT_RUNT]     = runt;
    status[STAT_OVERSIZE] = oversize;
    status[STAT_VALID]    = 1'b1;
    if (commit) begin
      last_csum_d   = csum_d;
      last_len_d    = len_d;
      last_status_d = status;
      last_src_d    = src_d;
      state_d       = ST_HDR;
      byte_cnt_d    = 16'd0;
      dst_d         = 48'd0;
      src_d         = 48'd0;
      len_d         = 16'd0;
      csum_d        = 32'd0;
    end
  end

  always_comb begin
    mac_d  = mac_q;
    ctrl_d = ctrl_q;
    thr_d  = thr_q;
    ok_d   = ok_q;
    bad_d  = bad_q;
    wsh    = {3'(ADDR_MAC5 - address), 3'b000};
    wmask  = 48'hFF << wsh;
    if (wr) begin
      if (address < ADDR_CTRL)           mac_d  = (mac_q & ~wmask) | ({40'd0, writedata} << wsh);
      else if (address == ADDR_CTRL)     ctrl_d = writedata & ~8'h02;
      else if (address == ADDR_THROTTLE) thr_d  = writedata;
    end
    if (commit) begin
      if (status[3:0] == 4'd0)     ok_d  = ok_q + 32'd1;
      else if (bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
    end
    if (clr) begin
      ok_d  = 32'd0;
      bad_d = 16'd0;
    end
  end

  always_comb begin
    rd = 8'd0;
    if (address < ADDR_CTRL)           rd = byte_of(mac_q, 3'(ADDR_MAC5 - address));
    else if (address == ADDR_CTRL)     rd = ctrl_q;
    else if (address == ADDR_THROTTLE) rd = thr_q;
    else if (address < ADDR_BAD0)      rd = byte_of({16'd0, ok_q}, 3'(address - ADDR_OK0));
    else if (address < ADDR_CSUM0)     rd = byte_of({32'd0, bad_q}, 3'(address - ADDR_BAD0));
    else if (address < ADDR_LEN0)      rd = byte_of({16'd0, last_csum_q}, 3'(address - ADDR_CSUM0));
    else if (address < ADDR_STATUS)    rd = byte_of({32'd0, last_len_q}, 3'(address - ADDR_LEN0));
    else if (address == ADDR_STATUS)   rd = last_status_q;
    else if (address <= ADDR_SRC5)     rd = byte_of(last_src_q, 3'(ADDR_SRC5 - address));
    readdata_d = (chipselect && read) ? rd : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ST_HDR;
      byte_cnt_q    <= 16'd0;
      dst_q         <= 48'd0;
      src_q         <= 48'd0;
      len_q         <= 16'd0;
      csum_q        <= 32'd0;
      mac_q         <= 48'd0;
      ctrl_q        <= 8'd0;
      thr_q         <= 8'd0;
      ok_q          <= 32'd0;
      bad_q         <= 16'd0;
      last_csum_q   <= 32'd0;
      last_len_q    <= 16'd0;
      last_status_q <= 8'd0;
      last_src_q    <= 48'd0;
      readdata_q    <= 8'd0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      dst_q         <= dst_d;
      src_q         <= src_d;
      len_q         <= len_d;
      csum_q        <= csum_d;
      mac_q         <= mac_d;
      ctrl_q        <= ctrl_d;
      thr_q         <= thr_d;
      ok_q          <= ok_d;
      bad_q         <= bad_d;
      last_csum_q   <= last_csum_d;
      last_len_q    <= last_len_d;
      last_status_q <= last_status_d;
      last_src_q    <= last_src_d;
      readdata_q    <= readdata_d;
    end
  end

endmodule

// File: tb/tb_frame_checker.sv
// Directed bench for frame_checker: a table of frames with hand-computed
// results, then sequences for throttle, oversize, commit-edge and reset cases.
module tb_frame_checker;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  writedata = 8'd0, address = 8'd0;
  logic        write = 1'b0, chipselect = 1'b0, read = 1'b0;
  logic [15:0] tdata = 16'd0;
  logic        tlast = 1'b0, tvalid = 1'b0;
  logic [7:0]  rd_a, rd_b;
  logic        rdy_a, rdy_b;

  int vecs = 0;
  int errs = 0;

  localparam logic [47:0] SRC_MAC    = 48'h0A0B0C0D0E0F;
  localparam logic [47:0] SRC_MAC_LE = 48'h0F0E0D0C0B0A;
  localparam logic [47:0] MAC1       = 48'h020000000001;
  localparam logic [47:0] MAC2       = 48'h020000000002;

  always #5 clk = ~clk;

  frame_checker #(.STUBBING(1), .MAX_FRAME_BYTES(1518)) dut_a (
    .clk(clk), .reset_n(reset_n), .writedata(writedata), .write(write),
    .chipselect(chipselect), .address(address), .read(read), .readdata(rd_a),
    .ingress_port_tdata(tdata), .ingress_port_tlast(tlast),
    .ingress_port_tvalid(tvalid), .ingress_port_tready(rdy_a));

  frame_checker #(.STUBBING(1), .MAX_FRAME_BYTES(32)) dut_b (
    .clk(clk), .reset_n(reset_n), .writedata(writedata), .write(write),
    .chipselect(chipselect), .address(address), .read(read), .readdata(rd_b),
    .ingress_port_tdata(tdata), .ingress_port_tlast(tlast),
    .ingress_port_tvalid(tvalid), .ingress_port_tready(rdy_b));

  typedef struct {
    logic [47:0] dst;
    logic [15:0] len;
    int          nbeats;
    logic        filt;
    logic [47:0] mac;
    logic [7:0]  e_status;
    logic [31:0] e_csum;
    logic [15:0] e_len;
    logic [31:0] e_ok;
    logic [15:0] e_bad;
  } vec_t;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [7:0] va, output logic [7:0] vb);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    va = rd_a; vb = rd_b;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic rd_multi(input logic [7:0] a, input int n, output logic [47:0] va, output logic [47:0] vb);
    logic [7:0] x, y;
    va = 48'd0; vb = 48'd0;
    for (int i = 0; i < n; i++) begin
      rd_reg(a + 8'(i), x, y);
      va = va | ({40'd0, x} << (8 * i));
      vb = vb | ({40'd0, y} << (8 * i));
    end
  endtask

  function automatic logic [15:0] beat(input logic [47:0] dst, input logic [15:0] len, input int i);
    int k;
    case (i)
      0: return dst[47:32];
      1: return dst[31:16];
      2: return dst[15:0];
      3: return SRC_MAC[47:32];
      4: return SRC_MAC[31:16];
      5: return SRC_MAC[15:0];
      6: return {len[7:0], len[15:8]};
      7: return 16'h0800;
      default: begin
        k = i - 8;
        return {8'(2 * k + 1), 8'(2 * k + 2)};
      end
    endcase
  endfunction

  task automatic send_beat(input logic [15:0] d, input logic l);
    int   guard;
    logic took;
    guard = 0;
    tdata = d; tlast = l; tvalid = 1'b1;
    do begin
      took = rdy_a;
      @(negedge clk);
      guard++;
    end while (!took && guard < 50);
    if (!took) check("tready_timeout", {47'd0, took}, 48'd1);
  endtask

  // Sends beats [0, upto) of a frame whose last beat index is nbeats-1.
  task automatic send_beats(input logic [47:0] dst, input logic [15:0] len, input int nbeats, input int upto);
    for (int i = 0; i < upto; i++) send_beat(beat(dst, len, i), i == nbeats - 1);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  int   mon_en = 0, mon_cyc = 0, mon_prev = -1, mon_lows = 0, mon_bad = 0;

  always @(negedge clk) begin
    if (mon_en != 0) begin
      mon_cyc++;
      if (!rdy_a) begin
        if (mon_prev >= 0 && (mon_cyc - mon_prev) != 4) mon_bad++;
        mon_prev = mon_cyc;
        mon_lows++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  vec_t        tbl[9];
  logic [47:0] va, vb, m;
  logic [7:0]  xa, xb;

  initial begin
    tbl[0] = '{MAC1, 16'd4,  10, 1'b0, MAC1, 8'h80, 32'h0A, 16'd4,  32'd1, 16'd0};
    tbl[1] = '{MAC1, 16'd4,  10, 1'b1, MAC2, 8'h82, 32'h0A, 16'd4,  32'd1, 16'd1};
    tbl[2] = '{MAC1, 16'd4,   6, 1'b0, MAC1, 8'h84, 32'h00, 16'd0,  32'd1, 16'd2};
    tbl[3] = '{MAC1, 16'd4,  10, 1'b0, MAC1, 8'h80, 32'h0A, 16'd4,  32'd2, 16'd2};
    tbl[4] = '{MAC1, 16'd10, 10, 1'b0, MAC1, 8'h81, 32'h0A, 16'd10, 32'd2, 16'd3};
    tbl[5] = '{MAC1, 16'd3,  10, 1'b0, MAC1, 8'h80, 32'h0A, 16'd3,  32'd3, 16'd3};
    tbl[6] = '{MAC1, 16'd0,   8, 1'b0, MAC1, 8'h80, 32'h00, 16'd0,  32'd4, 16'd3};
    tbl[7] = '{MAC1, 16'd0,   8, 1'b1, MAC1, 8'h80, 32'h00, 16'd0,  32'd5, 16'd3};
    tbl[8] = '{MAC1, 16'd2,   8, 1'b0, MAC1, 8'h81, 32'h00, 16'd2,  32'd5, 16'd4};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_readdata_a", {40'd0, rd_a}, 48'd0);
    check("rst_tready_a", {47'd0, rdy_a}, 48'd0);
    check("rst_tready_b", {47'd0, rdy_b}, 48'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_tready", {47'd0, rdy_a}, 48'd1);
    rd_multi(8'd8, 4, va, vb);  check("rst_frames_ok", va, 48'd0);
    rd_reg(8'd20, xa, xb);      check("rst_status", {40'd0, xa}, 48'd0);

    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 6; j++) begin
        m = tbl[i].mac >> (8 * (5 - j));
        wr_reg(8'(j), m[7:0]);
      end
      wr_reg(8'd6, {7'd0, tbl[i].filt});
      send_beats(tbl[i].dst, tbl[i].len, tbl[i].nbeats, tbl[i].nbeats);
      rd_reg(8'd20, xa, xb);
      check($sformatf("v%0d_status", i), {40'd0, xa}, {40'd0, tbl[i].e_status});
      check($sformatf("v%0d_status_b", i), {40'd0, xb}, {40'd0, tbl[i].e_status});
      rd_multi(8'd14, 4, va, vb); check($sformatf("v%0d_csum", i), va, {16'd0, tbl[i].e_csum});
      rd_multi(8'd18, 2, va, vb); check($sformatf("v%0d_len", i), va, {32'd0, tbl[i].e_len});
      rd_multi(8'd8, 4, va, vb);  check($sformatf("v%0d_ok", i), va, {16'd0, tbl[i].e_ok});
      rd_multi(8'd12, 2, va, vb); check($sformatf("v%0d_bad", i), va, {32'd0, tbl[i].e_bad});
      rd_multi(8'd21, 6, va, vb); check($sformatf("v%0d_src", i), va, SRC_MAC_LE);
    end

    rd_multi(8'd0, 6, va, vb);  check("mac_readback", va, 48'h010000000002);
    rd_reg(8'd200, xa, xb);     check("unmapped_read", {40'd0, xa}, 48'd0);
    wr_reg(8'd30, 8'h5A);
    rd_reg(8'd30, xa, xb);      check("unmapped_write", {40'd0, xa}, 48'd0);

    // Throttle N=3 with continuous tvalid over a 36-byte frame (sum 1..20)
    wr_reg(8'd7, 8'd3);
    mon_en = 1;
    send_beats(MAC1, 16'd20, 18, 18);
    mon_en = 0;
    check("thr_gap_errors", 48'(mon_bad), 48'd0);
    check("thr_lows_seen", {47'd0, mon_lows >= 3}, 48'd1);
    rd_reg(8'd7, xa, xb);       check("thr_readback", {40'd0, xa}, 48'd3);
    rd_reg(8'd20, xa, xb);      check("thr_status", {40'd0, xa}, 48'h80);
    rd_multi(8'd14, 4, va, vb); check("thr_csum", va, 48'hD2);
    rd_multi(8'd8, 4, va, vb);  check("thr_ok", va, 48'd6);
    wr_reg(8'd7, 8'd0);

    // 40-byte frame: oversize on the 32-byte instance; clear lands on the commit edge
    send_beats(MAC1, 16'd24, 20, 19);
    check("clr_edge_ready", {47'd0, rdy_a}, 48'd1);
    tdata = beat(MAC1, 16'd24, 19); tlast = 1'b1; tvalid = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = 8'd6; writedata = 8'h02;
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; chipselect = 1'b0; write = 1'b0;
    rd_reg(8'd20, xa, xb);
    check("ovr_status_a", {40'd0, xa}, 48'h80);
    check("ovr_status_b", {40'd0, xb}, 48'h88);
    rd_multi(8'd14, 4, va, vb);
    check("ovr_csum_a", va, 48'h12C);
    check("ovr_csum_b", vb, 48'h88);
    rd_multi(8'd12, 2, va, vb);
    check("clr_bad_a", va, 48'd0);
    check("clr_bad_b", vb, 48'd0);
    rd_multi(8'd8, 4, va, vb);
    check("clr_ok_a", va, 48'd0);
    rd_reg(8'd6, xa, xb);       check("ctrl_selfclear", {40'd0, xa}, 48'd0);

    // Read sampled on the commit edge returns the pre-commit count
    send_beats(MAC1, 16'd4, 10, 9);
    tdata = beat(MAC1, 16'd4, 9); tlast = 1'b1; tvalid = 1'b1;
    chipselect = 1'b1; read = 1'b1; address = 8'd8;
    @(negedge clk);
    check("commit_edge_read", {40'd0, rd_a}, 48'd0);
    tvalid = 1'b0; tlast = 1'b0; chipselect = 1'b0; read = 1'b0;
    @(negedge clk);
    check("idle_readdata", {40'd0, rd_a}, 48'd0);
    rd_reg(8'd8, xa, xb);       check("after_commit_ok", {40'd0, xa}, 48'd1);

    // Reset in the middle of a frame
    send_beats(MAC1, 16'd4, 10, 4);
    chipselect = 1'b1; read = 1'b1; address = 8'd8;
    @(negedge clk);
    check("pre_reset_read", {40'd0, rd_a}, 48'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_readdata", {40'd0, rd_a}, 48'd0);
    check("mid_rst_tready", {47'd0, rdy_a}, 48'd0);
    @(negedge clk);
    check("mid_rst_readdata2", {40'd0, rd_a}, 48'd0);
    check("mid_rst_tready_b", {47'd0, rdy_b}, 48'd0);
    reset_n = 1'b1; chipselect = 1'b0; read = 1'b0;
    @(negedge clk);
    check("mid_rst_release_ready", {47'd0, rdy_a}, 48'd1);
    rd_multi(8'd8, 4, va, vb);  check("mid_rst_ok", va, 48'd0);
    rd_reg(8'd20, xa, xb);      check("mid_rst_status", {40'd0, xa}, 48'd0);
    send_beats(MAC1, 16'd4, 10, 10);
    rd_multi(8'd8, 4, va, vb);  check("post_rst_frame_ok", va, 48'd1);
    rd_reg(8'd20, xa, xb);      check("post_rst_frame_status", {40'd0, xa}, 48'h80);
    rd_multi(8'd14, 4, va, vb); check("post_rst_frame_csum", va, 48'h0A);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
